alu_share_arbiter: RTL and testbench



---
 rtl/alu_share_arbiter.sv | 169 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one combinational ALU between two requesters (0: execute stage,
// 1: branch/address helper). At most one request is granted per cycle using
// round-robin arbitration. The granted operands/opcode drive the ALU, and the
// ALU result/zero flag are captured into a one-entry response register that
// belongs to the granted requester.
//
// Ports
//   clk, reset_n                       clock (rising edge), async active-low reset
//   reqN_valid/ready/a/b/op            request channel per requester (N = 0, 1)
//   rspN_valid/ready/result/zero       response channel per requester
//   alu_srca/alu_srcb/alu_operation    drive to the shared ALU
//   alu_result/alu_zero                return from the shared ALU
//   conflict_cnt                       saturating count of cycles with both requesters eligible
module alu_share_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,

    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [DATA_WIDTH-1:0]    req0_a,
    input  logic [DATA_WIDTH-1:0]    req0_b,
    input  logic [OPCODE_LENGTH-1:0] req0_op,

    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [DATA_WIDTH-1:0]    req1_a,
    input  logic [DATA_WIDTH-1:0]    req1_b,
    input  logic [OPCODE_LENGTH-1:0] req1_op,

    output logic                     rsp0_valid,
    input  logic                     rsp0_ready,
    output logic [DATA_WIDTH-1:0]    rsp0_result,
    output logic                     rsp0_zero,

    output logic                     rsp1_valid,
    input  logic                     rsp1_ready,
    output logic [DATA_WIDTH-1:0]    rsp1_result,
    output logic                     rsp1_zero,

    output logic [DATA_WIDTH-1:0]    alu_srca,
    output logic [DATA_WIDTH-1:0]    alu_srcb,
    output logic [OPCODE_LENGTH-1:0] alu_operation,
    input  logic [DATA_WIDTH-1:0]    alu_result,
    input  logic                     alu_zero,

    output logic [CNT_WIDTH-1:0]     conflict_cnt
);

    // run_q is cleared asynchronously by reset and set on the first clock
    // edge after release. Gating eligibility with it guarantees no grant
    // while reset is asserted without routing the reset net into the
    // combinational grant path.
    logic                  run_q;
    logic                  last_grant_q, last_grant_d;
    logic                  rsp0_valid_q, rsp0_valid_d;
    logic                  rsp1_valid_q, rsp1_valid_d;
    logic [DATA_WIDTH-1:0] rsp0_result_q, rsp0_result_d;
    logic [DATA_WIDTH-1:0] rsp1_result_q, rsp1_result_d;
    logic                  rsp0_zero_q, rsp0_zero_d;
    logic                  rsp1_zero_q, rsp1_zero_d;
    logic [CNT_WIDTH-1:0]  conflict_cnt_q, conflict_cnt_d;

    logic elig0, elig1, both_elig;
    logic grant0, grant1;

    always_comb begin
        // A full slot that is draining this cycle can accept a new result.
        elig0     = run_q && req0_valid && (!rsp0_valid_q || rsp0_ready);
        elig1     = run_q && req1_valid && (!rsp1_valid_q || rsp1_ready);
        both_elig = elig0 && elig1;

        // On a conflict the requester that did not win last time is chosen.
        grant0 = elig0 && (!elig1 ||  last_grant_q);
        grant1 = elig1 && (!elig0 || !last_grant_q);
    end

    always_comb begin
        alu_srca      = '0;
        alu_srcb      = '0;
        alu_operation = '0;
        if (grant0) begin
            alu_srca      = req0_a;
            alu_srcb      = req0_b;
            alu_operation = req0_op;
        end else if (grant1) begin
            alu_srca      = req1_a;
            alu_srcb      = req1_b;
            alu_operation = req1_op;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant0) begin
            last_grant_d = 1'b0;
        end else if (grant1) begin
            last_grant_d = 1'b1;
        end

        // A grant loads the slot even when the old entry drains in the same
        // cycle, so back-to-back operations see no bubble.
        rsp0_valid_d  = rsp0_valid_q;
        rsp0_result_d = rsp0_result_q;
        rsp0_zero_d   = rsp0_zero_q;
        if (grant0) begin
            rsp0_valid_d  = 1'b1;
            rsp0_result_d = alu_result;
            rsp0_zero_d   = alu_zero;
        end else if (rsp0_valid_q && rsp0_ready) begin
            rsp0_valid_d  = 1'b0;
        end

        rsp1_valid_d  = rsp1_valid_q;
        rsp1_result_d = rsp1_result_q;
        rsp1_zero_d   = rsp1_zero_q;
        if (grant1) begin
            rsp1_valid_d  = 1'b1;
            rsp1_result_d = alu_result;
            rsp1_zero_d   = alu_zero;
        end else if (rsp1_valid_q && rsp1_ready) begin
            rsp1_valid_d  = 1'b0;
        end

        conflict_cnt_d = conflict_cnt_q;
        if (both_elig && (conflict_cnt_q != {CNT_WIDTH{1'b1}})) begin
            conflict_cnt_d = conflict_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q          <= 1'b0;
            last_grant_q   <= 1'b1;
            rsp0_valid_q   <= 1'b0;
            rsp1_valid_q   <= 1'b0;
            rsp0_result_q  <= '0;
            rsp1_result_q  <= '0;
            rsp0_zero_q    <= 1'b0;
            rsp1_zero_q    <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            run_q          <= 1'b1;
            last_grant_q   <= last_grant_d;
            rsp0_valid_q   <= rsp0_valid_d;
            rsp1_valid_q   <= rsp1_valid_d;
            rsp0_result_q  <= rsp0_result_d;
            rsp1_result_q  <= rsp1_result_d;
            rsp0_zero_q    <= rsp0_zero_d;
            rsp1_zero_q    <= rsp1_zero_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign req0_ready   = grant0;
    assign req1_ready   = grant1;
    assign rsp0_valid   = rsp0_valid_q;
    assign rsp1_valid   = rsp1_valid_q;
    assign rsp0_result  = rsp0_result_q;
    assign rsp1_result  = rsp1_result_q;
    assign rsp0_zero    = rsp0_zero_q;
    assign rsp1_zero    = rsp1_zero_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: directed scenarios with hand-computed
// expectations. A small ALU stub closes the loop from alu_* outputs back to
// alu_result/alu_zero. A second instance with a 2-bit conflict counter
// shares the request inputs to exercise saturation.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_zero, rsp1_zero;
    logic [31:0] alu_srca, alu_srcb, alu_result;
    logic [3:0]  alu_operation;
    logic        alu_zero;
    logic [15:0] conflict_cnt;

    logic        req0_ready2, req1_ready2, rsp0_valid2, rsp1_valid2;
    logic        rsp0_zero2, rsp1_zero2;
    logic [31:0] rsp0_result2, rsp1_result2, alu_srca2, alu_srcb2;
    logic [3:0]  alu_operation2;
    logic [1:0]  conflict_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // ALU stub: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1001 signed SLT.
    // The flag it returns is high when the result is non-zero.
    always_comb begin
        case (alu_operation)
            4'b0000: alu_result = alu_srca & alu_srcb;
            4'b0001: alu_result = alu_srca | alu_srcb;
            4'b0010: alu_result = alu_srca + alu_srcb;
            4'b0110: alu_result = alu_srca - alu_srcb;
            4'b1001: alu_result = {31'b0, ($signed(alu_srca) < $signed(alu_srcb))};
            default: alu_result = 32'h0;
        endcase
        alu_zero = (alu_result != 32'h0);
    end

    alu_share_arbiter u_dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_operation(alu_operation),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .conflict_cnt(conflict_cnt)
    );

    alu_share_arbiter #(.CNT_WIDTH(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready2), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready2), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid2), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result2), .rsp0_zero(rsp0_zero2),
        .rsp1_valid(rsp1_valid2), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result2), .rsp1_zero(rsp1_zero2),
        .alu_srca(alu_srca2), .alu_srcb(alu_srcb2), .alu_operation(alu_operation2),
        .alu_result(32'h0), .alu_zero(1'b0),
        .conflict_cnt(conflict_cnt2)
    );

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            $display("FAIL reset_no_grant: got %b expected 00", {req0_ready, req1_ready}); errors++;
        end
        @(posedge clk); #1;
        checks++;
        if ({rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero} !== 4'b0000) begin
            $display("FAIL reset_flags: got %b expected 0000", {rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero}); errors++;
        end
        checks++;
        if (rsp0_result !== 32'h0 || rsp1_result !== 32'h0 || conflict_cnt !== 16'h0) begin
            $display("FAIL reset_values: got %h %h %h expected 0 0 0", rsp0_result, rsp1_result, conflict_cnt); errors++;
        end
        do_reset();
    endtask

    task automatic test_single_req0();
        do_reset();
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 4'b0010; rsp0_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || alu_srca !== 32'd5 || alu_srcb !== 32'd3 || alu_operation !== 4'b0010) begin
            $display("FAIL single_grant: got rdy=%b a=%0d b=%0d op=%b expected 1 5 3 0010",
                     req0_ready, alu_srca, alu_srcb, alu_operation); errors++;
        end
        @(posedge clk); #1;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd8 || rsp0_zero !== 1'b1) begin
            $display("FAIL single_rsp: got v=%b r=%0d z=%b expected 1 8 1", rsp0_valid, rsp0_result, rsp0_zero); errors++;
        end
        checks++;
        if (rsp1_valid !== 1'b0) begin
            $display("FAIL single_rsp1_idle: got %b expected 0", rsp1_valid); errors++;
        end
        @(negedge clk);
        req0_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rsp0_valid !== 1'b0 || rsp0_result !== 32'd8) begin
            $display("FAIL single_drain: got v=%b r=%0d expected 0 8", rsp0_valid, rsp0_result); errors++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd4; req0_op = 4'b0110;
            req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_op = 4'b1001;
            rsp0_ready = 1'b1; rsp1_ready = 1'b1;
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                $display("FAIL rr_grant[%0d]: got %b expected %b", i, {req0_ready, req1_ready},
                         (i % 2 == 0) ? 2'b10 : 2'b01); errors++;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (rsp0_result !== 32'd6 || rsp0_zero !== 1'b1) begin
            $display("FAIL rr_rsp0: got r=%0d z=%b expected 6 1", rsp0_result, rsp0_zero); errors++;
        end
        checks++;
        if (rsp1_result !== 32'd1 || rsp1_zero !== 1'b1) begin
            $display("FAIL rr_rsp1: got r=%0d z=%b expected 1 1", rsp1_result, rsp1_zero); errors++;
        end
        checks++;
        if (conflict_cnt !== 16'd4) begin
            $display("FAIL rr_conflict_cnt: got %0d expected 4", conflict_cnt); errors++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 4'b0010;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            $display("FAIL bp_first_grant: got %b expected 1", req0_ready); errors++;
        end
        @(posedge clk);
        @(negedge clk);
        req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1'b1; req1_a = 32'hF0; req1_b = 32'h3C; req1_op = 4'b0000;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01 || alu_srca !== 32'hF0) begin
            $display("FAIL bp_stall_grant: got rdy=%b a=%h expected 01 f0", {req0_ready, req1_ready}, alu_srca); errors++;
        end
        @(posedge clk); #1;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd8) begin
            $display("FAIL bp_rsp0_stable: got v=%b r=%0d expected 1 8", rsp0_valid, rsp0_result); errors++;
        end
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_result !== 32'h30) begin
            $display("FAIL bp_rsp1: got v=%b r=%h expected 1 30", rsp1_valid, rsp1_result); errors++;
        end
        @(negedge clk);
        req1_valid = 1'b0; rsp0_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            $display("FAIL bp_drain_grant: got %b expected 1", req0_ready); errors++;
        end
        @(posedge clk); #1;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd2 || conflict_cnt !== 16'd0) begin
            $display("FAIL bp_reload: got v=%b r=%0d cnt=%0d expected 1 2 0", rsp0_valid, rsp0_result, conflict_cnt); errors++;
        end
    endtask

    task automatic test_no_grant();
        do_reset();
        req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd2; req0_op = 4'b0001;
        req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd4; req1_op = 4'b0110;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            $display("FAIL ng_fill1: got %b expected 01", {req0_ready, req1_ready}); errors++;
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            $display("FAIL ng_ready: got %b expected 00", {req0_ready, req1_ready}); errors++;
        end
        checks++;
        if (alu_srca !== 32'h0 || alu_srcb !== 32'h0 || alu_operation !== 4'h0) begin
            $display("FAIL ng_alu_idle: got %h %h %h expected 0 0 0", alu_srca, alu_srcb, alu_operation); errors++;
        end
        @(posedge clk); #1;
        checks++;
        if (conflict_cnt !== 16'd1 || rsp0_result !== 32'd7 || rsp1_result !== 32'd5) begin
            $display("FAIL ng_hold: got cnt=%0d r0=%0d r1=%0d expected 1 7 5", conflict_cnt, rsp0_result, rsp1_result); errors++;
        end
    endtask

    task automatic test_async_reset();
        // Both slots are full from test_no_grant.
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 4'b0000) begin
            $display("FAIL ar_clear: got %b expected 0000", {rsp0_valid, rsp1_valid, req0_ready, req1_ready}); errors++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            $display("FAIL ar_first_conflict: got %b expected 10", {req0_ready, req1_ready}); errors++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        int exp;
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            if (k != 1) @(negedge clk);
            req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 4'b0010;
            req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_op = 4'b0010;
            rsp0_ready = 1'b1; rsp1_ready = 1'b1;
            @(posedge clk); #1;
            exp = (k > 3) ? 3 : k;
            checks++;
            if (conflict_cnt2 !== 2'(exp) || conflict_cnt !== 16'(k)) begin
                $display("FAIL sat_cnt[%0d]: got %0d/%0d expected %0d/%0d", k, conflict_cnt2, conflict_cnt, exp, k); errors++;
            end
        end
    endtask

    initial begin
        reset_n = 1'b1;
        idle_inputs();
        test_reset();
        test_single_req0();
        test_back_to_back();
        test_backpressure();
        test_no_grant();
        test_async_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
